mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side handshake bundle for mem_arbiter.
// The master modport is the arbiter's view; slave is the requesters-plus-memory view.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ*32-1:0] req_addr_i;
    logic [NUM_REQ-1:0]    resp_valid_o;
    logic [NUM_REQ-1:0]    resp_ready_i;
    logic [31:0]           resp_data_o;
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic [31:0]           mem_addr_o;
    logic                  mem_resp_valid_i;
    logic                  mem_resp_ready_o;
    logic [31:0]           mem_data_i;

    modport master (
        input  req_valid_i, req_addr_i, resp_ready_i,
        input  mem_req_ready_i, mem_resp_valid_i, mem_data_i,
        output req_ready_o, resp_valid_o, resp_data_o,
        output mem_req_valid_o, mem_addr_o, mem_resp_ready_o
    );

    modport slave (
        output req_valid_i, req_addr_i, resp_ready_i,
        output mem_req_ready_i, mem_resp_valid_i, mem_data_i,
        input  req_ready_o, resp_valid_o, resp_data_o,
        input  mem_req_valid_o, mem_addr_o, mem_resp_ready_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory among NUM_REQ requesters, one read in flight at a time.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module mem_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.master   bus,
    output logic            busy_o,
    output logic [ID_W-1:0] grant_id_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        req_addr [NUM_REQ];
    logic               any_req;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    base;
    logic [ID_W:0]      cand;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] resp_valid;
    logic               mem_req_valid;
    logic               mem_resp_ready;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
        assign req_addr[gi] = bus.req_addr_i[32*gi +: 32];
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && any_req)
            rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr_q <= '0;
        else      rr_ptr_q <= rr_ptr_d;
    end

    assign base = rr_ptr_q;
`endif

    // Scan upward from base, wrapping at NUM_REQ so non-power-of-2 counts never alias.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, base} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!any_req && bus.req_valid_i[cand[ID_W-1:0]]) begin
                any_req = 1'b1;
                winner  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        req_ready      = '0;
        resp_valid     = '0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    req_ready[winner] = 1'b1;
                    owner_d           = winner;
                    addr_d            = req_addr[winner];
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (bus.mem_req_ready_i)
                    state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                resp_valid[owner_q] = bus.mem_resp_valid_i;
                mem_resp_ready      = bus.resp_ready_i[owner_q];
                if (bus.mem_resp_valid_i && bus.resp_ready_i[owner_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
        end
    end

    // Grant is combinational from IDLE, which reset forces, so mask it while reset is held.
    assign bus.req_ready_o      = rst ? req_ready : '0;
    assign bus.resp_valid_o     = resp_valid;
    assign bus.resp_data_o      = bus.mem_data_i;
    assign bus.mem_req_valid_o  = mem_req_valid;
    assign bus.mem_addr_o       = addr_q;
    assign bus.mem_resp_ready_o = mem_resp_ready;
    assign busy_o               = (state_q != IDLE);
    assign grant_id_o           = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: page-table scenarios and a randomized run, every cycle
// compared against a transaction-level model of grants, issue and response routing.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0][31:0] req_addr;
    logic [NUM_REQ-1:0]       resp_ready;
    logic                     mem_req_ready;
    logic                     mem_resp_valid;
    logic [31:0]              mem_data;
    logic                     busy;
    logic [ID_W-1:0]          gid;

    mem_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
    assign bus.req_valid_i      = req_valid;
    assign bus.req_addr_i       = req_addr;
    assign bus.resp_ready_i     = resp_ready;
    assign bus.mem_req_ready_i  = mem_req_ready;
    assign bus.mem_resp_valid_i = mem_resp_valid;
    assign bus.mem_data_i       = mem_data;

    mem_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .busy_o     (busy),
        .grant_id_o (gid)
    );

    int checks = 0;
    int errors = 0;
    bit rand_mode = 1'b0;
    logic [31:0] req_q [NUM_REQ][$];
    int resp_stall [NUM_REQ];
    int rdy_cnt [NUM_REQ];
    int served [NUM_REQ];
    int issued [NUM_REQ];
    int stall_seen = 0;
    logic [31:0] resp_log [$];
    int resp_id_log [$];
    int gid_log [$];

    // Transaction-level model state
    bit          m_busy = 1'b0;
    bit          m_acc  = 1'b0;
    int          m_owner = 0;
    int          m_rr = 0;
    logic [31:0] m_addr = '0;
    bit          prev_busy = 1'b0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h0000_0400: return 32'h0000_0801;
            32'h0000_0800: return 32'h1000_000F;
            32'h0000_0804: return 32'h1100_000F;
            default:       return (a < 32'h1000) ? {a[15:0], ~a[15:0]} : 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] resp_at(input int i);
        return (i < resp_log.size()) ? resp_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int id_at(input int i);
        return (i < resp_id_log.size()) ? resp_id_log[i] : -1;
    endfunction

    function automatic int gid_at(input int i);
        return (i < gid_log.size()) ? gid_log[i] : -1;
    endfunction

    function automatic int pick();
        int b;
`ifdef MEM_ARB_FIXED_PRIO_EN
        b = 0;
`else
        b = m_rr;
`endif
        for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[(b + i) % NUM_REQ]) return (b + i) % NUM_REQ;
        return -1;
    endfunction

    task automatic model_step();
        int w;
        logic [NUM_REQ-1:0] e_rdy, e_rv;
        logic e_mrv, e_mrr;
        chk("resp_data_pass", bus.resp_data_o, mem_data);
        if (!rst) begin
            chk("rst_req_ready", bus.req_ready_o, 0);
            chk("rst_resp_valid", bus.resp_valid_o, 0);
            chk("rst_mem_req_valid", bus.mem_req_valid_o, 0);
            chk("rst_mem_resp_ready", bus.mem_resp_ready_o, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant_id", gid, 0);
            chk("rst_mem_addr", bus.mem_addr_o, 0);
            m_busy = 1'b0; m_acc = 1'b0; m_owner = 0; m_rr = 0; m_addr = '0; prev_busy = 1'b0;
            return;
        end
        for (int k = 0; k < NUM_REQ; k++)
            if (bus.req_ready_o[k]) rdy_cnt[k]++;
        w = m_busy ? -1 : pick();
        e_rdy = '0;
        if (w >= 0) e_rdy[w] = 1'b1;
        e_mrv = m_busy && !m_acc;
        e_rv  = '0;
        e_mrr = 1'b0;
        if (m_busy && m_acc) begin
            if (mem_resp_valid) e_rv[m_owner] = 1'b1;
            e_mrr = resp_ready[m_owner];
        end
        chk("req_ready", bus.req_ready_o, e_rdy);
        chk("mem_req_valid", bus.mem_req_valid_o, e_mrv);
        chk("mem_addr", bus.mem_addr_o, m_addr);
        chk("resp_valid", bus.resp_valid_o, e_rv);
        chk("mem_resp_ready", bus.mem_resp_ready_o, e_mrr);
        chk("busy", busy, m_busy);
        chk("grant_id", gid, m_owner);
        if (busy && !prev_busy) gid_log.push_back(int'(gid));
        prev_busy = busy;
        if (w >= 0) begin
            m_busy = 1'b1; m_acc = 1'b0; m_owner = w;
            m_addr = req_addr[w];
            m_rr   = (w + 1) % NUM_REQ;
        end else if (m_busy && !m_acc) begin
            if (mem_req_ready) m_acc = 1'b1;
        end else if (m_busy && mem_resp_valid && resp_ready[m_owner]) begin
            chk("resp_data", bus.resp_data_o, mem_read(m_addr));
            resp_log.push_back(bus.resp_data_o);
            resp_id_log.push_back(m_owner);
            served[m_owner]++;
            $display("txn: req%0d addr 0x%08h data 0x%08h", m_owner, m_addr, bus.resp_data_o);
            m_busy = 1'b0;
        end
    endtask

    initial begin : model
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    // Requesters and memory: sample handshakes on the falling edge, drive after the rising edge.
    initial begin : driver
        bit [NUM_REQ-1:0] req_fire;
        bit               mem_req_fire, mem_resp_fire, mem_pending;
        int               mem_delay;
        logic [31:0]      mem_addr_s, mem_addr_lat;
        mem_pending = 1'b0; mem_delay = 0; mem_addr_lat = '0;
        req_valid = '0; req_addr = '0; resp_ready = '1;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_data = '0;
        forever begin
            @(negedge clk);
            req_fire      = req_valid & bus.req_ready_o;
            mem_req_fire  = bus.mem_req_valid_o && mem_req_ready;
            mem_resp_fire = mem_resp_valid && bus.mem_resp_ready_o;
            mem_addr_s    = bus.mem_addr_o;
            for (int k = 0; k < NUM_REQ; k++)
                if (bus.resp_valid_o[k] && !resp_ready[k] && resp_stall[k] > 0) begin
                    resp_stall[k]--;
                    stall_seen++;
                end
            @(posedge clk);
            #1;
            if (!rst) begin
                req_valid = '0; mem_pending = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
                continue;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_fire[k]) begin
                    req_valid[k] = 1'b0;
                    void'(req_q[k].pop_front());
                end
                if (!req_valid[k] && req_q[k].size() > 0 &&
                    (!rand_mode || $urandom_range(0, 3) != 0)) begin
                    req_valid[k] = 1'b1;
                    req_addr[k]  = req_q[k][0];
                end
                if (resp_stall[k] > 0) resp_ready[k] = 1'b0;
                else resp_ready[k] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (mem_resp_fire) begin
                mem_resp_valid = 1'b0;
                mem_pending    = 1'b0;
            end
            if (mem_req_fire) begin
                mem_pending    = 1'b1;
                mem_resp_valid = 1'b0;
                mem_addr_lat   = mem_addr_s;
                mem_delay      = rand_mode ? int'($urandom_range(0, 3)) : 1;
            end
            if (mem_pending && !mem_resp_valid) begin
                if (mem_delay == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_data       = mem_read(mem_addr_lat);
                end else begin
                    mem_delay--;
                    mem_data = $urandom;
                end
            end else if (!mem_pending) begin
                // Stray responses outside a transaction must be ignored by the arbiter.
                mem_resp_valid = rand_mode && ($urandom_range(0, 4) == 0);
                mem_data       = $urandom;
            end
            mem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        resp_log.delete(); resp_id_log.delete(); gid_log.delete();
        stall_seen = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rdy_cnt[k] = 0; served[k] = 0; issued[k] = 0; resp_stall[k] = 0;
        end
    endtask

    task automatic wait_resps(input int n, input string name);
        int cyc = 0;
        while (resp_log.size() < n && cyc < 8000) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        chk({name, "_resp_count"}, resp_log.size(), n);
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int found, k;
        logic [31:0] a;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_stall[i] = 0; rdy_cnt[i] = 0; served[i] = 0; issued[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("por_busy", busy, 0);
        chk("por_grant_id", gid, 0);
        chk("por_mem_addr", bus.mem_addr_o, 0);
        @(negedge clk);
        #2 rst = 1'b1;

        // 1: single request
        do_reset();
        req_q[0].push_back(32'h400);
        wait_resps(1, "t1");
        chk("t1_ready_pulses0", rdy_cnt[0], 1);
        chk("t1_ready_pulses1", rdy_cnt[1], 0);
        chk("t1_grant", gid_at(0), 0);
        chk("t1_data", resp_at(0), 32'h0000_0801);

        // 2: contention from reset
        do_reset();
        req_q[0].push_back(32'h800);
        req_q[1].push_back(32'h804);
        wait_resps(2, "t2");
        chk("t2_grant0", gid_at(0), 0);
        chk("t2_grant1", gid_at(1), 1);
        chk("t2_data0", resp_at(0), 32'h1000_000F);
        chk("t2_data1", resp_at(1), 32'h1100_000F);
        chk("t2_owner1", id_at(1), 1);

        // 3: fairness with both requesters continuously pending
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_q[0].push_back(32'h400);
            req_q[1].push_back(32'h800);
        end
        wait_resps(12, "t3");
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            chk($sformatf("t3_seq%0d", i), gid_at(i), 0);
`else
            chk($sformatf("t3_seq%0d", i), gid_at(i), i % 2);
`endif
        end

        // 4: owner backpressure for 5 cycles with another requester waiting
        do_reset();
        resp_stall[0] = 5;
        req_q[0].push_back(32'h400);
        req_q[1].push_back(32'h800);
        wait_resps(2, "t4");
        chk("t4_stall_cycles", stall_seen, 5);
        chk("t4_data0", resp_at(0), 32'h0000_0801);
        chk("t4_grant1", gid_at(1), 1);
        chk("t4_data1", resp_at(1), 32'h1000_000F);

        // 5: address outside the image reads zero
        do_reset();
        req_q[1].push_back(32'h1000);
        wait_resps(1, "t5");
        chk("t5_data", resp_at(0), 32'h0);
        chk("t5_owner", id_at(0), 1);
        chk("t5_idle", busy, 0);

        // 6: asynchronous reset while the response is being presented
        do_reset();
        resp_stall[1] = 20;
        req_q[1].push_back(32'h800);
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(negedge clk);
            if (busy && bus.resp_valid_o[1]) found = 1;
        end
        chk("t6_reached_wait", found, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_resp_valid", bus.resp_valid_o, 0);
        chk("t6_mem_req_valid", bus.mem_req_valid_o, 0);
        chk("t6_mem_resp_ready", bus.mem_resp_ready_o, 0);
        chk("t6_req_ready", bus.req_ready_o, 0);
        chk("t6_grant_id", gid, 0);
        chk("t6_mem_addr", bus.mem_addr_o, 0);
        resp_stall[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        resp_log.delete(); resp_id_log.delete(); gid_log.delete();
        req_q[1].push_back(32'h804);
        wait_resps(1, "t6_after");
        chk("t6_after_data", resp_at(0), 32'h1100_000F);

        // Randomized traffic, handshakes and memory timing
        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(0, NUM_REQ - 1));
            case ($urandom_range(0, 4))
                0:       a = 32'h400;
                1:       a = 32'h800;
                2:       a = 32'h804;
                3:       a = {20'h0, $urandom_range(0, 1023), 2'b00};
                default: a = 32'h1000 + {$urandom_range(0, 4095), 2'b00};
            endcase
            req_q[k].push_back(a);
            issued[k]++;
        end
        wait_resps(300, "rand");
        rand_mode = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            chk($sformatf("rand_served%0d", i), served[i], issued[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
